ir_tx: RTL and testbench

NEC-format infrared transmitter for a 27 MHz clock domain. It serialises a 16-bit code (address byte, command byte) into a complete NEC frame: lead mark/space, 32 data bits (address, ~address, command, ~command), and a stop mark. While hold is asserted it emits NEC repeat codes every 108 ms. It drives an active-low envelope output with the same polarity and timing that the IR receive path decodes, plus an optional 38 kHz modulated LED drive.

---
 rtl/ir_tx.sv | 121 ++++++++++++
 tb/tb_ir_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_tx.sv
// ir_tx: NEC infrared transmitter, full frames plus 108 ms repeat codes while held,
// active-low envelope and optional carrier-modulated LED drive.
module ir_tx #(
   parameter int LEAD_MARK    = 243000,
   parameter int LEAD_SPACE   = 121500,
   parameter int RPT_SPACE    = 60750,
   parameter int BIT_MARK     = 15120,
   parameter int SPACE_ZERO   = 15120,
   parameter int SPACE_ONE    = 45630,
   parameter int FRAME_PERIOD = 2916000,
   parameter int CARRIER_HALF = 355,
   parameter bit CARRIER_EN   = 1'b1
) (
   input  logic        clk27,
   input  logic        reset_n,
   input  logic [15:0] tx_code,
   input  logic        tx_start,
   input  logic        tx_hold,
   output logic        busy,
   output logic        tx_done,
   output logic        ir_tx_n,
   output logic        ir_led
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_LEAD_MARK = 4'd1;
   localparam logic [3:0] S_LEAD_SPC  = 4'd2;
   localparam logic [3:0] S_BIT_MARK  = 4'd3;
   localparam logic [3:0] S_BIT_SPC   = 4'd4;
   localparam logic [3:0] S_STOP_MARK = 4'd5;
   localparam logic [3:0] S_GAP       = 4'd6;
   localparam logic [3:0] S_RPT_MARK  = 4'd7;
   localparam logic [3:0] S_RPT_SPC   = 4'd8;
   localparam logic [3:0] S_RPT_STOP  = 4'd9;

   logic [3:0]  state_q, state_d;
   logic [17:0] ph_q, ph_d, len;
   logic [21:0] per_q, per_d;
   logic [31:0] sh_q, sh_d;
   logic [5:0]  bit_q, bit_d;
   logic [15:0] car_q, car_d;
   logic        cph_q, cph_d, mark_d, ph_end, gap_end, car_end, lead_in;
   logic        busy_q, done_q, txn_q, led_q;

   function automatic logic is_mark(input logic [3:0] s);
      return s == S_LEAD_MARK || s == S_BIT_MARK || s == S_STOP_MARK || s == S_RPT_MARK || s == S_RPT_STOP;
   endfunction

   always_comb begin
      len = (state_q == S_LEAD_MARK || state_q == S_RPT_MARK) ? 18'(LEAD_MARK) :
            state_q == S_LEAD_SPC ? 18'(LEAD_SPACE) :
            state_q == S_RPT_SPC  ? 18'(RPT_SPACE) :
            state_q == S_BIT_SPC  ? (sh_q[31] ? 18'(SPACE_ONE) : 18'(SPACE_ZERO)) : 18'(BIT_MARK);
      ph_end  = ph_q == len - 18'd1;
      gap_end = per_q == 22'(FRAME_PERIOD - 1);
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: if (tx_start) begin
            state_d = S_LEAD_MARK;
            sh_d    = {tx_code[15:8], ~tx_code[15:8], tx_code[7:0], ~tx_code[7:0]};
            bit_d   = '0;
         end
         S_LEAD_MARK: if (ph_end) state_d = S_LEAD_SPC;
         S_LEAD_SPC:  if (ph_end) state_d = S_BIT_MARK;
         S_BIT_MARK:  if (ph_end) state_d = S_BIT_SPC;
         S_BIT_SPC: if (ph_end) begin
            sh_d    = {sh_q[30:0], 1'b0};
            bit_d   = bit_q + 6'd1;
            state_d = bit_q == 6'd31 ? S_STOP_MARK : S_BIT_MARK;
         end
         S_STOP_MARK: if (ph_end) state_d = S_GAP;
         S_GAP:       if (gap_end) state_d = tx_hold ? S_RPT_MARK : S_IDLE;
         S_RPT_MARK:  if (ph_end) state_d = S_RPT_SPC;
         S_RPT_SPC:   if (ph_end) state_d = S_RPT_STOP;
         S_RPT_STOP:  if (ph_end) state_d = S_GAP;
         default:     state_d = S_IDLE;
      endcase
      ph_d    = (state_d != state_q || state_q == S_IDLE || state_q == S_GAP) ? '0 : ph_q + 18'd1;
      lead_in = (state_d == S_LEAD_MARK || state_d == S_RPT_MARK) && state_d != state_q;
      per_d   = (lead_in || state_d == S_IDLE) ? '0 : per_q + 22'd1;
      // carrier restarts high on every entry into a mark
      mark_d  = is_mark(state_d);
      car_end = car_q == 16'(CARRIER_HALF - 1);
      car_d   = (mark_d && is_mark(state_q) && !car_end) ? car_q + 16'd1 : '0;
      cph_d   = !is_mark(state_q) ? 1'b1 : car_end ? ~cph_q : cph_q;
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         per_q   <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         car_q   <= '0;
         cph_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         txn_q   <= 1'b1;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         per_q   <= per_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         car_q   <= car_d;
         cph_q   <= cph_d;
         busy_q  <= state_d != S_IDLE;
         done_q  <= state_q == S_GAP && gap_end && !tx_hold;
         txn_q   <= ~mark_d;
         led_q   <= CARRIER_EN ? (mark_d & cph_d) : mark_d;
      end
   end

   assign busy    = busy_q;
   assign tx_done = done_q;
   assign ir_tx_n = txn_q;
   assign ir_led  = led_q;
endmodule

// File: tb/tb_ir_tx.sv
// tb_ir_tx: randomized frames/repeats against a waveform-level NEC model, scaled timing.
module tb_ir_tx;
   localparam int LM = 40, LS = 20, RS = 10, BM = 5, S0 = 5, S1 = 14, FP = 720, CH = 3;

   logic        clk27 = 1'b0, reset_n = 1'b0, tx_start = 1'b0, tx_hold = 1'b0;
   logic [15:0] tx_code = '0;
   logic        busy, tx_done, ir_tx_n, ir_led, busy0, done0, txn0, led0;
   int          checks = 0, errors = 0, cyc = 0;
   bit          env [FP];
   bit          car [FP];
   int          m_len, m_t;
   logic [31:0] m_word;
   bit          m_busy;
   logic        e_busy = 1'b0, e_done = 1'b0, e_n = 1'b1, e_led = 1'b0, e_led0 = 1'b0;
   logic [15:0] codes [4] = '{16'h0000, 16'hFFFF, 16'h5AA5, 16'h1A2B};

   always #5 clk27 = ~clk27;
   always @(negedge clk27) cyc <= cyc + 1;

   ir_tx #(.LEAD_MARK(LM), .LEAD_SPACE(LS), .RPT_SPACE(RS), .BIT_MARK(BM), .SPACE_ZERO(S0),
           .SPACE_ONE(S1), .FRAME_PERIOD(FP), .CARRIER_HALF(CH), .CARRIER_EN(1'b1)) dut (
      .clk27(clk27), .reset_n(reset_n), .tx_code(tx_code), .tx_start(tx_start), .tx_hold(tx_hold),
      .busy(busy), .tx_done(tx_done), .ir_tx_n(ir_tx_n), .ir_led(ir_led));

   ir_tx #(.LEAD_MARK(LM), .LEAD_SPACE(LS), .RPT_SPACE(RS), .BIT_MARK(BM), .SPACE_ZERO(S0),
           .SPACE_ONE(S1), .FRAME_PERIOD(FP), .CARRIER_HALF(CH), .CARRIER_EN(1'b0)) dut0 (
      .clk27(clk27), .reset_n(reset_n), .tx_code(tx_code), .tx_start(tx_start), .tx_hold(tx_hold),
      .busy(busy0), .tx_done(done0), .ir_tx_n(txn0), .ir_led(led0));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // append a mark or space segment to the expected period waveform
   task automatic seg(input bit m, input int n);
      for (int k = 0; k < n; k++) begin
         if (m_len < FP) begin
            env[m_len] = m;
            car[m_len] = m && ((k / CH) % 2 == 0);
         end
         m_len++;
      end
   endtask

   task automatic clear_wave();
      for (int i = 0; i < FP; i++) begin
         env[i] = 1'b0;
         car[i] = 1'b0;
      end
      m_len = 0;
   endtask

   task automatic build_frame(input logic [15:0] c);
      clear_wave();
      m_word = {c[15:8], ~c[15:8], c[7:0], ~c[7:0]};
      seg(1'b1, LM);
      seg(1'b0, LS);
      for (int i = 31; i >= 0; i--) begin
         seg(1'b1, BM);
         seg(1'b0, m_word[i] ? S1 : S0);
      end
      seg(1'b1, BM);
   endtask

   task automatic build_rpt();
      clear_wave();
      seg(1'b1, LM);
      seg(1'b0, RS);
      seg(1'b1, BM);
   endtask

   // reference: each period is a precomputed waveform indexed by time since its lead
   initial forever begin
      @(posedge clk27 or negedge reset_n);
      if (!reset_n) begin
         m_busy = 1'b0;
         e_busy = 1'b0;
         e_done = 1'b0;
         e_n    = 1'b1;
         e_led  = 1'b0;
         e_led0 = 1'b0;
      end else begin
         e_done = 1'b0;
         if (!m_busy) begin
            if (tx_start) begin
               build_frame(tx_code);
               m_busy = 1'b1;
               m_t    = 0;
            end
         end else if (m_t == FP - 1) begin
            if (tx_hold) begin
               build_rpt();
               m_t = 0;
            end else begin
               m_busy = 1'b0;
               e_done = 1'b1;
            end
         end else m_t++;
         e_busy = m_busy;
         e_n    = !(m_busy && env[m_t]);
         e_led  = m_busy && car[m_t];
         e_led0 = !e_n;
      end
   end

   initial forever begin
      @(negedge clk27);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("tx_done", 32'(tx_done), 32'(e_done));
      chk("ir_tx_n", 32'(ir_tx_n), 32'(e_n));
      chk("ir_led", 32'(ir_led), 32'(e_led));
      chk("busy_nocar", 32'(busy0), 32'(e_busy));
      chk("tx_done_nocar", 32'(done0), 32'(e_done));
      chk("ir_tx_n_nocar", 32'(txn0), 32'(e_n));
      chk("ir_led_nocar", 32'(led0), 32'(e_led0));
   end

   initial begin
      repeat (90000) @(posedge clk27);
      errors++;
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (ir_tx_n === lvl && n < FP) begin
         n++;
         @(negedge clk27);
      end
   endtask

   task automatic wait_done(input int bound);
      int n;
      n = 0;
      while (tx_done !== 1'b1 && n < bound) begin
         @(negedge clk27);
         n++;
      end
      chk("done_seen", 32'(tx_done), 32'd1);
   endtask

   initial begin
      int n, t0, rel;
      logic [31:0] w;
      bit hold;
      build_frame(16'h1A2B);
      chk("model_word", m_word, 32'h1AE52BD4);
      chk("model_len", 32'(m_len), 32'd529);
      chk("model_env", 32'({env[39], env[40], env[60]}), 32'b101);
      chk("model_car", 32'({car[0], car[2], car[3], car[6]}), 32'b1101);
      build_rpt();
      chk("model_rpt_len", 32'(m_len), 32'd55);
      tx_start = 1'b1;
      repeat (5) @(negedge clk27);
      reset_n  = 1'b1;
      tx_start = 1'b0;
      repeat (50) @(negedge clk27);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_n", 32'(ir_tx_n), 32'd1);
      chk("idle_led", 32'(ir_led), 32'd0);

      tx_code  = 16'h1A2B;
      tx_start = 1'b1;
      @(negedge clk27);
      tx_start = 1'b0;
      chk("start_n", 32'(ir_tx_n), 32'd0);
      chk("start_led", 32'(ir_led), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      t0 = cyc;
      fork
         begin
            run_len(1'b0, n);
            chk("lead_mark", 32'(n), 32'(LM));
            run_len(1'b1, n);
            chk("lead_space", 32'(n), 32'(LS));
            w = '0;
            for (int i = 0; i < 32; i++) begin
               run_len(1'b0, n);
               chk("bit_mark", 32'(n), 32'(BM));
               run_len(1'b1, n);
               w = {w[30:0], n == S1};
            end
            chk("data_word", w, 32'h1AE52BD4);
            run_len(1'b0, n);
            chk("stop_mark", 32'(n), 32'(BM));
            wait_done(2 * FP);
            chk("done_time", 32'(cyc - t0), 32'(FP));
         end
         begin
            repeat (100) @(negedge clk27);
            tx_code  = 16'hFFFF;
            tx_start = 1'b1;
            @(negedge clk27);
            tx_start = 1'b0;
            tx_code  = 16'h0F0F;
         end
      join

      for (int it = 0; it < 10; it++) begin
         hold     = it == 1 || $urandom_range(0, 3) == 0;
         rel      = hold ? int'($urandom_range(FP, 2 * FP + FP / 2)) : 0;
         tx_code  = it < 4 ? codes[it] : 16'($urandom);
         tx_hold  = hold;
         tx_start = 1'b1;
         @(negedge clk27);
         n = 0;
         while (tx_done !== 1'b1 && n < 6 * FP) begin
            tx_start = $urandom_range(0, 39) == 0;
            tx_code  = 16'($urandom);
            if (n == rel) tx_hold = 1'b0;
            @(negedge clk27);
            n++;
         end
         chk("done_seen", 32'(tx_done), 32'd1);
         tx_start = 1'b0;
         tx_hold  = 1'b0;
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 20)) @(negedge clk27);
      end
      tx_start = 1'b0;
      repeat (10) @(negedge clk27);

      tx_code  = 16'h0000;
      tx_start = 1'b1;
      @(negedge clk27);
      tx_start = 1'b0;
      repeat (180) @(negedge clk27);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_n", 32'(ir_tx_n), 32'd1);
      chk("rst_led", 32'(ir_led), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      repeat (3) @(negedge clk27);
      reset_n = 1'b1;
      repeat (5) @(negedge clk27);
      tx_code  = 16'hC3A7;
      tx_start = 1'b1;
      @(negedge clk27);
      tx_start = 1'b0;
      wait_done(2 * FP);
      repeat (5) @(negedge clk27);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
